// File: rtl/if_fetch_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_pkg
//   Shared types and constants for the instruction-fetch stage.
//   - if_state_t : FETCH collects four bytes, HOLD presents the instruction
//   - RST_ENABLE : active level of the asynchronous reset
//   - ZERO_WORD  : reset value of the 32-bit outputs
//   - INST_LEN   : pc increment per instruction (bytes)
//   - byte_addr(): 32-bit address of byte k of the instruction at pc
// ---------------------------------------------------------------------------
package if_fetch_pkg;

    localparam logic        RST_ENABLE = 1'b1;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
    localparam logic [31:0] INST_LEN   = 32'd4;

    typedef enum logic [1:0] {
        IF_FETCH = 2'd0,
        IF_HOLD  = 2'd1
    } if_state_t;

    // The sum wraps in 32 bits; callers truncate to the RAM width afterwards.
    function automatic logic [31:0] byte_addr(input logic [31:0] pc,
                                              input logic [2:0]  k);
        return pc + {29'd0, k};
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// ---------------------------------------------------------------------------
// if_fetch_if
//   Bundles the fetch stage's control inputs, RAM read port and decode-side
//   outputs.
//   master : the fetch stage (drives RAM strobe/address and pc/inst outputs)
//   slave  : the surrounding pipeline/RAM (drives stall, redirect, busy, data)
//   Signals:
//     stall_i          decode cannot accept; hold current output
//     branch_i         taken branch/jump resolved in execute this cycle
//     branch_target_i  redirect pc
//     mem_busy_i       data port owns the RAM this cycle
//     ram_rd_o         read strobe for ram_addr_o
//     ram_addr_o       byte address (ADDR_WIDTH bits)
//     ram_data_i       byte returned one cycle after the strobe
//     pc_o / inst_o    pc and assembled little-endian instruction
//     inst_valid_o     pc_o/inst_o valid for decode
// ---------------------------------------------------------------------------
interface if_fetch_if #(
    parameter int ADDR_WIDTH = 17
) ();

    logic                  stall_i;
    logic                  branch_i;
    logic [31:0]           branch_target_i;
    logic                  mem_busy_i;
    logic                  ram_rd_o;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic [7:0]            ram_data_i;
    logic [31:0]           pc_o;
    logic [31:0]           inst_o;
    logic                  inst_valid_o;

    modport master (
        input  stall_i, branch_i, branch_target_i, mem_busy_i, ram_data_i,
        output ram_rd_o, ram_addr_o, pc_o, inst_o, inst_valid_o
    );

    modport slave (
        output stall_i, branch_i, branch_target_i, mem_busy_i, ram_data_i,
        input  ram_rd_o, ram_addr_o, pc_o, inst_o, inst_valid_o
    );

endinterface

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
//   Instruction-fetch stage. Reads four bytes from a byte-wide RAM with
//   one-cycle read latency, assembles them little-endian into a 32-bit
//   instruction and presents pc/inst to decode, holding them while decode
//   stalls. A taken branch from execute redirects the pc and drops any
//   in-flight fetch.
//   Ports:
//     clk  : system clock, rising edge
//     rst  : asynchronous, active-high reset
//     bus  : if_fetch_if.master (control inputs, RAM port, decode outputs)
//   Parameters:
//     ADDR_WIDTH : RAM byte-address width (pc is truncated to this)
//     RESET_PC   : first fetch address after reset
// ---------------------------------------------------------------------------
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int          ADDR_WIDTH = 17,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    if_fetch_if.master bus
);

    if_state_t   r_state,     w_state_nxt;
    logic [31:0] r_pc,        w_pc_nxt;
    logic [2:0]  r_issue_cnt, w_issue_cnt_nxt;   // bytes requested so far, 0..4
    logic        r_pending,   w_pending_nxt;     // a byte returns this cycle
    logic [1:0]  r_pend_idx,  w_pend_idx_nxt;    // lane that returning byte fills
    logic [23:0] r_lanes,     w_lanes_nxt;       // bytes 0..2 of the instruction
    logic [31:0] r_inst,      w_inst_nxt;
    logic [31:0] r_pc_out,    w_pc_out_nxt;

    logic        w_issue;

    // A strobe is suppressed in a redirect cycle: its data would be discarded.
    assign w_issue = (r_state == IF_FETCH) && (r_issue_cnt < 3'd4) &&
                     !bus.mem_busy_i && !bus.branch_i && (rst != RST_ENABLE);

    assign bus.ram_rd_o     = w_issue;
    assign bus.ram_addr_o   = w_issue ? ADDR_WIDTH'(byte_addr(r_pc, r_issue_cnt))
                                      : '0;
    assign bus.pc_o         = r_pc_out;
    assign bus.inst_o       = r_inst;
    assign bus.inst_valid_o = (r_state == IF_HOLD);

    always_comb begin
        // NOTE: every next value is defaulted before any branch so no path
        // leaves one unassigned, which would otherwise infer a latch.
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_issue_cnt_nxt = r_issue_cnt;
        w_pending_nxt   = 1'b0;
        w_pend_idx_nxt  = r_pend_idx;
        w_lanes_nxt     = r_lanes;
        w_inst_nxt      = r_inst;
        w_pc_out_nxt    = r_pc_out;

        if (bus.branch_i) begin
            // Redirect wins over stall, consumption and busy; the byte that
            // returns next cycle is dropped because pending is cleared.
            w_state_nxt     = IF_FETCH;
            w_pc_nxt        = bus.branch_target_i;
            w_issue_cnt_nxt = 3'd0;
        end else begin
            case (r_state)
                IF_FETCH: begin
                    if (w_issue) begin
                        w_issue_cnt_nxt = r_issue_cnt + 3'd1;
                        w_pending_nxt   = 1'b1;
                        w_pend_idx_nxt  = r_issue_cnt[1:0];
                    end
                    // Returning data is captured even when the RAM is busy now.
                    if (r_pending) begin
                        case (r_pend_idx)
                            2'd0: w_lanes_nxt[7:0]   = bus.ram_data_i;
                            2'd1: w_lanes_nxt[15:8]  = bus.ram_data_i;
                            2'd2: w_lanes_nxt[23:16] = bus.ram_data_i;
                            default: begin
                                // Lane 3 goes straight into the output register,
                                // saving a cycle of latency.
                                w_inst_nxt   = {bus.ram_data_i, r_lanes};
                                w_pc_out_nxt = r_pc;
                                w_state_nxt  = IF_HOLD;
                            end
                        endcase
                    end
                end
                IF_HOLD: begin
                    if (!bus.stall_i) begin
                        w_pc_nxt        = r_pc + INST_LEN;
                        w_issue_cnt_nxt = 3'd0;
                        w_state_nxt     = IF_FETCH;
                    end
                end
                default: begin
                    w_state_nxt     = IF_FETCH;
                    w_issue_cnt_nxt = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            r_state     <= IF_FETCH;
            r_pc        <= RESET_PC;
            r_issue_cnt <= 3'd0;
            r_pending   <= 1'b0;
            r_pend_idx  <= 2'd0;
            r_lanes     <= 24'd0;
            r_inst      <= ZERO_WORD;
            r_pc_out    <= ZERO_WORD;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_issue_cnt <= w_issue_cnt_nxt;
            r_pending   <= w_pending_nxt;
            r_pend_idx  <= w_pend_idx_nxt;
            r_lanes     <= w_lanes_nxt;
            r_inst      <= w_inst_nxt;
            r_pc_out    <= w_pc_out_nxt;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch
//   Self-checking bench for if_fetch. A byte RAM model answers strobes one
//   cycle later (and returns junk otherwise). A transaction-level reference
//   tracks the expected pc, how many bytes of the current instruction have
//   been requested and when the instruction must appear; the expected
//   instruction word is read straight from the RAM image.
// ---------------------------------------------------------------------------
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam int          AW       = 17;
    localparam int          MEM_SIZE = 1 << AW;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    if_fetch_if #(.ADDR_WIDTH(AW)) bus ();

    if_fetch #(.ADDR_WIDTH(AW), .RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [MEM_SIZE];

    // RAM: one-cycle read latency; unrequested cycles return random bytes.
    always @(posedge clk) begin
        if (bus.ram_rd_o) bus.ram_data_i <= mem[bus.ram_addr_o];
        else              bus.ram_data_i <= 8'($urandom);
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        logic [31:0] a;
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            a = pc + 32'(k);
            w[8*k +: 8] = mem[a[AW-1:0]];
        end
        return w;
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    int          m_issued;     // bytes requested for the current instruction
    int          m_cd;         // cycles until the instruction must be valid
    bit          m_valid;
    logic [31:0] last_addr;    // most recent strobed address

    task automatic model_reset();
        m_pc     = RST_PC;
        m_inst   = ZERO_WORD;
        m_issued = 0;
        m_cd     = 0;
        m_valid  = 1'b0;
    endtask

    // Called mid-cycle (negedge) with inputs stable for this cycle.
    task automatic model_step();
        bit          exp_rd;
        logic [31:0] ea;
        exp_rd = !m_valid && (m_issued < 4) && !bus.mem_busy_i;
        ea     = m_pc + 32'(m_issued);

        if (bus.mem_busy_i)
            check("rd_while_busy", 32'(bus.ram_rd_o), 32'd0);
        else if (!bus.branch_i)
            check("ram_rd", 32'(bus.ram_rd_o), 32'(exp_rd));
        if (exp_rd && !bus.branch_i)
            check("ram_addr", 32'(bus.ram_addr_o), 32'(ea[AW-1:0]));
        if (bus.ram_rd_o) last_addr = 32'(bus.ram_addr_o);

        check("inst_valid", 32'(bus.inst_valid_o), 32'(m_valid));
        if (m_valid) begin
            check("pc_o", bus.pc_o, m_pc);
            check("inst_o", bus.inst_o, m_inst);
        end

        // Advance to the next cycle.
        if (bus.branch_i) begin
            m_pc     = bus.branch_target_i;
            m_issued = 0;
            m_cd     = 0;
            m_valid  = 1'b0;
        end else if (m_valid) begin
            if (!bus.stall_i) begin
                m_valid  = 1'b0;
                m_pc     = m_pc + 32'd4;
                m_issued = 0;
            end
        end else begin
            if (m_cd != 0) begin
                m_cd--;
                if (m_cd == 0) begin
                    m_valid = 1'b1;
                    m_inst  = mem_word(m_pc);
                end
            end
            if (exp_rd) begin
                m_issued++;
                // Last byte returns next cycle; valid the cycle after that.
                if (m_issued == 4) m_cd = 1;
            end
        end
    endtask

    // Drive one cycle of inputs, check mid-cycle, end at next posedge + 1.
    task automatic cyc(input bit s, input bit b, input logic [31:0] t,
                       input bit busy);
        bus.stall_i         = s;
        bus.branch_i        = b;
        bus.branch_target_i = t;
        bus.mem_busy_i      = busy;
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at posedge+1 of the first cycle after release.
    task automatic apply_reset(input bit mid);
        if (mid) begin
            #2;
            rst = 1'b1;
            #1;
            check("rst_valid", 32'(bus.inst_valid_o), 32'd0);
            check("rst_inst",  bus.inst_o, ZERO_WORD);
            check("rst_pc",    bus.pc_o, ZERO_WORD);
            check("rst_rd",    32'(bus.ram_rd_o), 32'd0);
            check("rst_addr",  32'(bus.ram_addr_o), 32'd0);
        end else begin
            rst = 1'b1;
        end
        bus.stall_i         = 1'b0;
        bus.branch_i        = 1'b0;
        bus.branch_target_i = 32'd0;
        bus.mem_busy_i      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] wrap_exp [4];

    initial begin
        for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'hA0; mem[3] = 8'h00;
        last_addr = '0;
        model_reset();
        bus.stall_i = 1'b0; bus.branch_i = 1'b0;
        bus.branch_target_i = 32'd0; bus.mem_busy_i = 1'b0;

        // Cold fetch: strobes cycles 1-4, valid on cycle 6, next strobe cycle 7.
        apply_reset(1'b0);
        check("reset_valid", 32'(bus.inst_valid_o), 32'd0);
        check("reset_pc", bus.pc_o, ZERO_WORD);
        repeat (5) cyc(1'b0, 1'b0, 32'd0, 1'b0);
        check("cold_valid", 32'(bus.inst_valid_o), 32'd1);
        check("cold_inst", bus.inst_o, 32'h00A0_0513);
        check("cold_pc", bus.pc_o, 32'd0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        check("cold_consumed", 32'(bus.inst_valid_o), 32'd0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        check("cold_next_addr", last_addr, 32'd4);

        // Busy for two cycles after the second strobe: valid slips to cycle 8.
        apply_reset(1'b0);
        repeat (2) cyc(1'b0, 1'b0, 32'd0, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 32'd0, 1'b1);
        repeat (2) cyc(1'b0, 1'b0, 32'd0, 1'b0);
        check("busy_not_yet", 32'(bus.inst_valid_o), 32'd0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        check("busy_valid", 32'(bus.inst_valid_o), 32'd1);
        check("busy_inst", bus.inst_o, 32'h00A0_0513);

        // Stall for three cycles, then release.
        repeat (3) cyc(1'b1, 1'b0, 32'd0, 1'b0);
        check("stall_valid", 32'(bus.inst_valid_o), 32'd1);
        check("stall_pc", bus.pc_o, 32'd0);
        check("stall_inst", bus.inst_o, 32'h00A0_0513);
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        check("stall_next_addr", last_addr, 32'd4);

        // Redirect in the cycle after the byte-2 strobe.
        apply_reset(1'b0);
        repeat (3) cyc(1'b0, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 1'b1, 32'h100, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        check("redir_first_addr", last_addr, 32'h100);
        repeat (4) cyc(1'b0, 1'b0, 32'd0, 1'b0);
        check("redir_valid", 32'(bus.inst_valid_o), 32'd1);
        check("redir_pc", bus.pc_o, 32'h100);
        check("redir_inst", bus.inst_o, mem_word(32'h100));

        // Redirect coincident with valid output and stall.
        cyc(1'b1, 1'b1, 32'h200, 1'b0);
        check("redir_stall_valid", 32'(bus.inst_valid_o), 32'd0);

        // Address wrap at the top of the RAM.
        wrap_exp[0] = 32'h1FFFE; wrap_exp[1] = 32'h1FFFF;
        wrap_exp[2] = 32'h00000; wrap_exp[3] = 32'h00001;
        cyc(1'b0, 1'b1, 32'h1FFFE, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b0, 32'd0, 1'b0);
            check("wrap_addr", last_addr, wrap_exp[k]);
        end
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        check("wrap_valid", 32'(bus.inst_valid_o), 32'd1);
        check("wrap_pc", bus.pc_o, 32'h1FFFE);
        check("wrap_inst", bus.inst_o, mem_word(32'h1FFFE));

        // Reset in the middle of the next fetch.
        repeat (3) cyc(1'b0, 1'b0, 32'd0, 1'b0);
        apply_reset(1'b1);
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        check("refetch_addr", last_addr, RST_PC);

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            case ($urandom_range(0, 2))
                0:       tgt = $urandom;
                1:       tgt = 32'h1FFFC + 32'($urandom_range(0, 7));
                default: tgt = 32'($urandom_range(0, 255));
            endcase
            if (i == 1500) apply_reset(1'b1);
            cyc($urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0, tgt,
                $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage. It produces the pc/instruction pair consumed by the decode stage through the IF/ID register.
- Reads a byte-wide unified RAM (one-cycle read latency) and assembles 4 little-endian bytes into a 32-bit instruction.
- Holds the instruction while decode is stalled.
- Redirects on branch/jump resolution from execute, discarding any in-flight fetch.

Parameters:
- ADDR_WIDTH, 17, RAM byte-address width; pc is truncated to this width on ram_addr_o.
- RESET_PC, 32'h0, first fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset (`RstEnable == 1'b1`).
- stall_i  in  1  decode stage cannot accept; hold current output.
- branch_i  in  1  execute resolved a taken branch/jump this cycle.
- branch_target_i  in  32  redirect pc.
- mem_busy_i  in  1  data port owns the RAM this cycle; no issue allowed.
- ram_rd_o  in/out: out  1  read strobe for ram_addr_o.
- ram_addr_o  out  ADDR_WIDTH  byte address.
- ram_data_i  in  8  byte returned one cycle after the strobe.
- pc_o  out  32  pc of inst_o.
- inst_o  out  32  assembled instruction.
- inst_valid_o  out  1  pc_o/inst_o valid for decode.

Behaviour:
- Reset (async, any state):
  - pc=RESET_PC; state=FETCH; issue_cnt=0; recv_cnt=0; pending=0.
  - Outputs: inst_valid_o=0, inst_o=`ZeroWord, pc_o=`ZeroWord, ram_rd_o=0, ram_addr_o=0.
  - Reset mid-fetch abandons the fetch; the first access after release is RESET_PC.
- RAM timing: ram_rd_o=1 with address A in cycle t gives byte A on ram_data_i in cycle t+1, regardless of mem_busy_i in t+1.
- FETCH state:
  - Each cycle with issue_cnt<4 and !mem_busy_i: ram_rd_o=1, ram_addr_o=(pc+issue_cnt)[ADDR_WIDTH-1:0], issue_cnt++, pending=1, pend_idx=issue_cnt.
  - mem_busy_i=1: ram_rd_o=0, issue_cnt holds; a byte returning from the previous cycle is still captured.
  - When pending is set, the next cycle captures ram_data_i into byte lane pend_idx (lane0=[7:0] ... lane3=[31:24]).
  - After lane 3 is captured, the next edge registers inst_o, pc_o=pc and inst_valid_o=1, then moves to HOLD.
  - Unstalled, unbusy latency: 4 issue cycles + 1 capture + 1 register → inst_valid_o rises 5 cycles after the first strobe.
- HOLD state:
  - inst_valid_o=1 and ram_rd_o=0; outputs are stable while stall_i=1.
  - stall_i=0 at a clock edge means consumed: pc+=4, issue_cnt=0, inst_valid_o=0, state=FETCH.
  - Throughput: one instruction per 6 cycles when unstalled.
- Redirect (branch_i=1, highest priority, any state):
  - Next edge: pc=branch_target_i; issue_cnt=0; pending=0 (a byte returning next cycle is discarded); inst_valid_o=0; state=FETCH.
  - Same-cycle stall_i, consumption and mem_busy_i are ignored for that edge.
  - The first strobe to the target occurs in the cycle after branch_i, if not busy.
  - branch_target_i[1:0] is used unaltered; no alignment trap.
- Address wrap: pc+k is computed in 32 bits, then truncated. pc=2^ADDR_WIDTH-2 fetches addresses 0x1FFFE, 0x1FFFF, 0x0, 0x1.
- ram_rd_o is never asserted when mem_busy_i=1, in HOLD, or during reset.

Decomposition:
- Shared defines file gains:
  - `IfStateBus (1:0), `IF_FETCH, `IF_HOLD
  - `RamAddrBus
  - `InstLen (32'd4)
- Reuse existing `InstAddrBus, `InstBus, `ZeroWord, `RstEnable.
- No sub-module: byte assembly and the counters live inline.

Test Plan:
- Cold fetch: RAM[0..3]=13 05 A0 00; reset release, no stall/busy → strobes at addresses 0,1,2,3 on cycles 1-4; inst_valid_o=1, inst_o=32'h00A00513, pc_o=0 on cycle 6; next strobe at address 4 on cycle 7.
- Busy insertion: mem_busy_i high for 2 cycles after the second strobe → addresses issued 0,1,(gap),(gap),2,3; inst_o is still correct and valid 2 cycles later than the cold case.
- Stall hold: stall_i high 3 cycles while valid → pc_o/inst_o/inst_valid_o unchanged, ram_rd_o=0 throughout; release → pc advances to 4.
- Redirect mid-fetch: branch_i=1, target=0x100 in the cycle after the byte-2 strobe → byte-2 data discarded, no valid output, next strobes 0x100..0x103; inst_o comes from RAM[0x100..0x103].
- Redirect vs. stall/valid: branch_i coincident with inst_valid_o=1 and stall_i=1 → inst_valid_o=0 next cycle, pc=target.
- Wrap and reset: pc=0x1FFFE → addresses 1FFFE, 1FFFF, 0, 1; asserting rst mid-fetch → all outputs zero immediately, refetch from RESET_PC.
